// File: rtl/alu_pkg.sv
// Shared opcode encodings and flag bit positions for the ALU datapath.
package alu_pkg;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_ORR = 3'b011;
    localparam logic [2:0] ALU_EOR = 3'b100;
    localparam logic [2:0] ALU_MUL = 3'b101;
    localparam logic [2:0] ALU_BIC = 3'b110;
    localparam logic [2:0] ALU_MOV = 3'b111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_b_shifter.sv
// Operand-B conditioning: optional logical left shift, selected per operation.
module b_shifter #(
    parameter int WIDTH = 5,
    parameter int SHW   = 2
) (
    input  logic [WIDTH-1:0] b_i,
    input  logic [SHW-1:0]   bshift_i,
    input  logic             select_i,
    output logic [WIDTH-1:0] b_eff_o
);

    // With select low the shift amount is ignored entirely, so X on it cannot leak through.
    always_comb begin
        b_eff_o = b_i;
        if (select_i) begin
            b_eff_o = b_i << bshift_i;
        end else begin
            b_eff_o = b_i;
        end
    end

endmodule

// File: rtl/alu_top.sv
// ARM-style ALU with NZCV flags; result and flags registered for one cycle of latency.
module alu_top
    import alu_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int SHW   = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [SHW-1:0]   bshift,
    input  logic             select,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags
);

    logic [WIDTH-1:0]   b_eff_s;
    logic [WIDTH:0]     sum_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   result_d;
    logic [WIDTH-1:0]   result_q;
    logic               carry_s;
    logic               ovf_s;
    logic [3:0]         flags_d;
    logic [3:0]         flags_q;

    b_shifter #(
        .WIDTH (WIDTH),
        .SHW   (SHW)
    ) u_b_shifter (
        .b_i      (b),
        .bshift_i (bshift),
        .select_i (select),
        .b_eff_o  (b_eff_s)
    );

    // Operation decode; C and V only come from the adder, and SUB feeds ~B' with carry-in 1.
    always_comb begin
        sum_s    = '0;
        prod_s   = '0;
        result_d = '0;
        carry_s  = 1'b0;
        ovf_s    = 1'b0;
        case (ALUControl)
            ALU_ADD: begin
                sum_s    = {1'b0, a} + {1'b0, b_eff_s};
                result_d = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (a[WIDTH-1] == b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_SUB: begin
                sum_s    = {1'b0, a} + {1'b0, ~b_eff_s} + {{WIDTH{1'b0}}, 1'b1};
                result_d = sum_s[WIDTH-1:0];
                carry_s  = sum_s[WIDTH];
                ovf_s    = (a[WIDTH-1] != b_eff_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
            end
            ALU_AND: result_d = a & b_eff_s;
            ALU_ORR: result_d = a | b_eff_s;
            ALU_EOR: result_d = a ^ b_eff_s;
            ALU_MUL: begin
                prod_s   = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b_eff_s};
                result_d = prod_s[WIDTH-1:0];
            end
            ALU_BIC: result_d = a & ~b_eff_s;
            ALU_MOV: result_d = b_eff_s;
            default: result_d = '0;
        endcase
    end

    // Flag assembly from the selected result.
    always_comb begin
        flags_d         = 4'b0000;
        flags_d[FLAG_N] = result_d[WIDTH-1];
        flags_d[FLAG_Z] = (result_d == '0);
        flags_d[FLAG_C] = carry_s;
        flags_d[FLAG_V] = ovf_s;
    end

    // Output register; cleared asynchronously while rst_n is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            flags_q  <= 4'b0000;
        end else begin
            result_q <= result_d;
            flags_q  <= flags_d;
        end
    end

    assign Result   = result_q;
    assign ALUFlags = flags_q;

endmodule

// File: tb/tb_alu_top.sv
// Self-checking bench for alu_top: directed vector table, reset sequence and randomized model check.
module tb_alu_top;

    localparam int W = 5;
    localparam int M = 1 << W;

    logic         clk;
    logic         rst_n;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [1:0]   bshift;
    logic         select;
    logic [2:0]   ALUControl;
    logic [W-1:0] Result;
    logic [3:0]   ALUFlags;

    int n_vec;
    int n_err;

    alu_top #(.WIDTH(W), .SHW(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .bshift     (bshift),
        .select     (select),
        .ALUControl (ALUControl),
        .Result     (Result),
        .ALUFlags   (ALUFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] a;
        logic [4:0] b;
        logic [1:0] sh;
        logic       sel;
        logic [2:0] op;
        logic [4:0] res;
        logic [3:0] fl;
    } vec_t;

    vec_t tbl[12];

    function automatic int sx(input int x);
        return (x >= M / 2) ? x - M : x;
    endfunction

    // Reference: plain integer arithmetic on the ARM rules.
    function automatic void ref_alu(input int av, input int bv, input int sh, input int sel,
                                    input int op, output int res, output int fl);
        int bp;
        int s;
        int c;
        int v;
        int n;
        int z;
        bp = sel ? ((bv * (1 << sh)) % M) : bv;
        c = 0;
        v = 0;
        s = 0;
        case (op)
            0: begin
                s = av + bp; res = s % M; c = (s >= M) ? 1 : 0;
                v = ((sx(av) + sx(bp)) > M / 2 - 1 || (sx(av) + sx(bp)) < -(M / 2)) ? 1 : 0;
            end
            1: begin
                s = av + (M - 1 - bp) + 1; res = s % M; c = (s >= M) ? 1 : 0;
                v = ((sx(av) - sx(bp)) > M / 2 - 1 || (sx(av) - sx(bp)) < -(M / 2)) ? 1 : 0;
            end
            2: res = av & bp;
            3: res = av | bp;
            4: res = av ^ bp;
            5: res = (av * bp) % M;
            6: res = av & ((M - 1) & ~bp);
            7: res = bp;
            default: res = 0;
        endcase
        n = (res >= M / 2) ? 1 : 0;
        z = (res == 0) ? 1 : 0;
        fl = n * 8 + z * 4 + c * 2 + v;
    endfunction

    task automatic check(input string nm, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [4:0] av, input logic [4:0] bv, input logic [1:0] sh,
                         input logic sel, input logic [2:0] op);
        @(negedge clk);
        a = av; b = bv; bshift = sh; select = sel; ALUControl = op;
    endtask

    initial begin
        int er;
        int ef;
        n_vec = 0;
        n_err = 0;

        tbl[0]  = '{"mul_neg",   5'b11100, 5'd5,     2'd0, 1'b0, 3'b101, 5'b01100, 4'b0000};
        tbl[1]  = '{"add_ovf",   5'd15,    5'd1,     2'd0, 1'b0, 3'b000, 5'b10000, 4'b1001};
        tbl[2]  = '{"sub_zero",  5'd5,     5'd5,     2'd0, 1'b0, 3'b001, 5'b00000, 4'b0110};
        tbl[3]  = '{"sub_borrow",5'd3,     5'd5,     2'd0, 1'b0, 3'b001, 5'b11110, 4'b1000};
        tbl[4]  = '{"shift_add", 5'd1,     5'b00011, 2'd2, 1'b1, 3'b000, 5'b01101, 4'b0000};
        tbl[5]  = '{"shift_mov", 5'd0,     5'b01001, 2'd2, 1'b1, 3'b111, 5'b00100, 4'b0000};
        tbl[6]  = '{"and",       5'b10110, 5'b01100, 2'd0, 1'b0, 3'b010, 5'b00100, 4'b0000};
        tbl[7]  = '{"orr",       5'b10110, 5'b01100, 2'd0, 1'b0, 3'b011, 5'b11110, 4'b1000};
        tbl[8]  = '{"eor",       5'b10110, 5'b01100, 2'd0, 1'b0, 3'b100, 5'b11010, 4'b1000};
        tbl[9]  = '{"bic",       5'b10110, 5'b01100, 2'd0, 1'b0, 3'b110, 5'b10010, 4'b1000};
        tbl[10] = '{"sel_sh0",   5'd7,     5'd9,     2'd0, 1'b1, 3'b000, 5'b10000, 4'b1001};
        tbl[11] = '{"nosel_sh3", 5'd7,     5'd9,     2'd3, 1'b0, 3'b111, 5'b01001, 4'b0000};

        rst_n = 1'b0; a = 5'd0; b = 5'd0; bshift = 2'd0; select = 1'b0; ALUControl = 3'd0;
        #12;
        check("reset_result", Result, 0);
        check("reset_flags", ALUFlags, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed table, applied back to back.
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].sel, tbl[i].op);
            @(posedge clk); #1;
            check({tbl[i].name, "_res"}, Result, tbl[i].res);
            check({tbl[i].name, "_flags"}, ALUFlags, tbl[i].fl);
        end

        // Asynchronous reset mid-cycle with nonzero outputs, held across an edge.
        drive(5'd15, 5'd1, 2'd0, 1'b0, 3'b000);
        @(posedge clk); #1;
        check("pre_reset_result", Result, 5'b10000);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_result", Result, 0);
        check("async_reset_flags", ALUFlags, 0);
        @(posedge clk); #1;
        check("held_reset_result", Result, 0);
        check("held_reset_flags", ALUFlags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post_reset_result", Result, 5'b10000);
        check("post_reset_flags", ALUFlags, 4'b1001);

        // Randomized back-to-back operations against the reference model.
        for (int i = 0; i < 400; i++) begin
            logic [4:0] ra;
            logic [4:0] rb;
            logic [1:0] rs;
            logic       rl;
            logic [2:0] ro;
            ra = 5'($urandom); rb = 5'($urandom); rs = 2'($urandom);
            rl = 1'($urandom); ro = 3'($urandom);
            ref_alu(int'(ra), int'(rb), int'(rs), int'(rl), int'(ro), er, ef);
            drive(ra, rb, rs, rl, ro);
            @(posedge clk); #1;
            check("rand_res", Result, er);
            check("rand_flags", ALUFlags, ef);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_top.md
Name: alu_top

Overview:
- 5-bit ARM-style ALU with an optional left-shifter on operand B.
- Computes arithmetic and logic results with NZCV flags.
- Result and flags are registered: one clock of latency.
- Standalone datapath block; later instantiated in the single-cycle processor's execute stage.

Parameters:
- WIDTH, 5, operand/result width. All widths below assume 5; the logic must scale with WIDTH.
- SHW, 2, width of the shift-amount input.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- a  in  WIDTH  operand A, two's complement
- b  in  WIDTH  operand B, two's complement
- bshift  in  SHW  logical-left shift amount for B (0..3)
- select  in  1  0 = use b unchanged; 1 = use b shifted
- ALUControl  in  3  operation code
- Result  out  WIDTH  registered result
- ALUFlags  out  4  registered flags {N,Z,C,V}: [3]=N, [2]=Z, [1]=C, [0]=V

Behaviour:
- Reset: rst_n low clears Result and ALUFlags to 0 immediately, with no clock needed. Outputs are held at 0 while rst_n stays low.
- Operand B path (combinational):
  - bs = (b << bshift), truncated to WIDTH; bits shifted out are discarded and zeros fill from the LSB.
  - B' = select ? bs : b.
- Operations (combinational on a, B'):
  - 000 ADD: a + B'
  - 001 SUB: a + ~B' + 1
  - 010 AND: a & B'
  - 011 ORR: a | B'
  - 100 EOR: a ^ B'
  - 101 MUL: low WIDTH bits of a*B'. Product bits are identical for signed and unsigned operands.
  - 110 BIC: a & ~B'
  - 111 MOV: B'
- Flags:
  - N = result[WIDTH-1].
  - Z = (result == 0).
  - C: ADD and SUB only. It is the carry out of the (WIDTH+1)-bit sum. For SUB, C=1 means no borrow (ARM convention).
  - V: ADD and SUB only. Set when the operands fed to the adder have the same sign and the sum's sign differs.
  - For all other ops, C=0 and V=0.
- Timing: on each rising clk edge with rst_n high, Result and ALUFlags load the combinational values. Latency is exactly 1 cycle, throughput is 1 op per cycle, and there is no handshake.
- Boundaries:
  - Arithmetic wraps mod 2^WIDTH.
  - bshift=0 with select=1 is identical to select=0.
  - If rst_n deasserts near a clock edge, the first capture occurs on the first edge where rst_n is high.
  - X on an unused input must not affect outputs. Example: with select=0, bshift is don't-care.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams: ALU_ADD=3'b000, ALU_SUB, ALU_AND, ALU_ORR, ALU_EOR, ALU_MUL, ALU_BIC, ALU_MOV
  - flag index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- One sub-module, b_shifter (combinational LSL plus select mux).
- The op decode and flag logic live in alu_top together with the output register.

Test Plan:
- Reset: drive rst_n=0 mid-run with nonzero outputs -> Result=00000 and ALUFlags=0000 without a clock edge; both stay 0 until rst_n=1 and the next edge.
- MUL: a=-4 (11100), b=5, ALUControl=101, select=0, bshift=0 -> after one edge Result=01100 (12), ALUFlags=0000.
- ADD overflow: a=15, b=1, op 000, select=0 -> Result=10000, ALUFlags=1001 (N=1, V=1).
- SUB zero: a=5, b=5, op 001 -> Result=00000, ALUFlags=0110 (Z=1, C=1).
- SUB borrow: a=3, b=5, op 001 -> Result=11110, ALUFlags=1000.
- Shifter, select=1:
  - b=00011, bshift=2, a=1, op 000 -> B'=01100, Result=01101, ALUFlags=0000.
  - b=01001, bshift=2, op 111 -> Result=00100; shifted-out bit is dropped.
- Logic ops: a=10110, b=01100, select=0:
  - AND -> 00100, flags 0000
  - ORR -> 11110, flags 1000
  - EOR -> 11010, flags 1000
  - BIC -> 10010, flags 1000
- Every check is sampled one cycle after the inputs are applied.
- Back-to-back ops must each appear on consecutive cycles.
